// File: rtl/multicycle_processor.sv
// 16-bit multicycle processor core. One shared datapath sequenced by a single FSM; every
// instruction takes 3 to 5 states. The instruction image is supplied flat by the surrounding
// system. The data RAM is internal and is loaded from the datamem image while rst is high.
//
// Ports:
//   clk       single clock, rising edge
//   rst       synchronous, active-high reset
//   pc_nu     start PC, loaded at reset
//   instrmem  instruction image, word i = bits [16i+15:16i]
//   datamem   initial data image, same packing, copied into the RAM at reset
//   pc        current PC
//   state     FSM state (FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, HALT=5)
//   halted    high while state==HALT
module multicycle_processor (
  input  logic           clk,
  input  logic           rst,
  input  logic [15:0]    pc_nu,
  input  logic [65535:0] instrmem,
  input  logic [65535:0] datamem,
  output logic [15:0]    pc,
  output logic [2:0]     state,
  output logic           halted
);

  typedef enum logic [2:0] {
    StFetch   = 3'd0,
    StDecode  = 3'd1,
    StExecute = 3'd2,
    StMem     = 3'd3,
    StWb      = 3'd4,
    StHalt    = 3'd5
  } state_e;

  localparam logic [3:0] OpAlu  = 4'h0;
  localparam logic [3:0] OpAddi = 4'h1;
  localparam logic [3:0] OpLw   = 4'h2;
  localparam logic [3:0] OpSw   = 4'h3;
  localparam logic [3:0] OpBeq  = 4'h4;
  localparam logic [3:0] OpBne  = 4'h5;
  localparam logic [3:0] OpJmp  = 4'h6;
  localparam logic [3:0] OpLi   = 4'h7;
  localparam logic [3:0] OpHalt = 4'hF;

  state_e      state_q;
  logic        halted_q;
  logic [15:0] pc_q;
  logic [15:0] ir_q;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [15:0] alu_out_q;
  logic [15:0] mdr_q;
  logic [15:0] rf_q [8];
  logic [15:0] dm_q [4096];

  // Instruction fields
  logic [3:0]  op;
  logic [2:0]  rd, rs, rt, funct;
  logic [15:0] imm6, imm9;
  logic [11:0] tgt;

  assign op    = ir_q[15:12];
  assign rd    = ir_q[11:9];
  assign rs    = ir_q[8:6];
  assign rt    = ir_q[5:3];
  assign funct = ir_q[2:0];
  assign imm6  = {{10{ir_q[5]}}, ir_q[5:0]};
  assign imm9  = {{7{ir_q[8]}}, ir_q[8:0]};
  assign tgt   = ir_q[11:0];

  // Shared ALU: register ops, address/immediate adds and branch targets.
  logic [15:0] alu_result;
  always_comb begin
    alu_result = a_q;
    unique case (op)
      OpAlu: begin
        unique case (funct)
          3'd0: alu_result = a_q + b_q;
          3'd1: alu_result = a_q - b_q;
          3'd2: alu_result = a_q & b_q;
          3'd3: alu_result = a_q | b_q;
          3'd4: alu_result = a_q ^ b_q;
          3'd5: alu_result = ($signed(a_q) < $signed(b_q)) ? 16'd1 : 16'd0;
          3'd6: alu_result = a_q << b_q[3:0];
          3'd7: alu_result = a_q >> b_q[3:0];
          default: alu_result = a_q;
        endcase
      end
      OpAddi, OpLw, OpSw: alu_result = a_q + imm6;
      OpBeq, OpBne:       alu_result = pc_q + imm6;
      OpLi:               alu_result = imm9;
      default:            alu_result = a_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFetch;
      halted_q  <= 1'b0;
      pc_q      <= pc_nu;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out_q <= '0;
      mdr_q     <= '0;
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
      for (int i = 0; i < 4096; i++) dm_q[i] <= datamem[16*i +: 16];
    end else begin
      unique case (state_q)
        StFetch: begin
          ir_q    <= instrmem[{pc_q[11:0], 4'h0} +: 16];
          pc_q    <= pc_q + 16'd1;
          state_q <= StDecode;
        end
        StDecode: begin
          a_q <= rf_q[rs];
          // SW stores rd and branches compare rd with rs, so B carries rd for those.
          b_q <= (op == OpSw || op == OpBeq || op == OpBne) ? rf_q[rd] : rf_q[rt];
          if (op == OpHalt) begin
            state_q  <= StHalt;
            halted_q <= 1'b1;
          end else begin
            state_q <= StExecute;
          end
        end
        StExecute: begin
          alu_out_q <= alu_result;
          unique case (op)
            OpAlu, OpAddi, OpLi: state_q <= StWb;
            OpLw, OpSw:          state_q <= StMem;
            OpBeq: begin
              if (a_q == b_q) pc_q <= alu_result;
              state_q <= StFetch;
            end
            OpBne: begin
              if (a_q != b_q) pc_q <= alu_result;
              state_q <= StFetch;
            end
            OpJmp: begin
              pc_q    <= {pc_q[15:12], tgt};
              state_q <= StFetch;
            end
            default: state_q <= StFetch;
          endcase
        end
        StMem: begin
          if (op == OpSw) begin
            dm_q[alu_out_q[11:0]] <= b_q;
            state_q <= StFetch;
          end else begin
            mdr_q   <= dm_q[alu_out_q[11:0]];
            state_q <= StWb;
          end
        end
        StWb: begin
          if (rd != 3'd0) rf_q[rd] <= (op == OpLw) ? mdr_q : alu_out_q;
          state_q <= StFetch;
        end
        StHalt: begin
          state_q <= StHalt;
        end
        default: begin
          state_q <= StFetch;
        end
      endcase
    end
  end

  assign pc     = pc_q;
  assign state  = state_q;
  assign halted = halted_q;

endmodule

// File: tb/tb_multicycle_processor.sv
module tb_multicycle_processor;

  logic           clk;
  logic           rst;
  logic [15:0]    pc_nu;
  logic [65535:0] instrmem;
  logic [65535:0] datamem;
  logic [15:0]    pc;
  logic [2:0]     state;
  logic           halted;

  int n_checks;
  int n_pass;

  multicycle_processor dut (
    .clk      (clk),
    .rst      (rst),
    .pc_nu    (pc_nu),
    .instrmem (instrmem),
    .datamem  (datamem),
    .pc       (pc),
    .state    (state),
    .halted   (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_iw(input int addr, input logic [15:0] val);
    instrmem[addr*16 +: 16] = val;
  endtask

  task automatic set_dw(input int addr, input logic [15:0] val);
    datamem[addr*16 +: 16] = val;
  endtask

  // Inputs change and outputs are sampled 1 time unit after a rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [15:0] start);
    pc_nu = start;
    rst   = 1'b1;
    step(2);
    rst   = 1'b0;
  endtask

  task automatic clear_mems();
    instrmem = '0;
    datamem  = '0;
  endtask

  task automatic test_reset();
    clear_mems();
    do_reset(16'h1234);
    n_checks++;
    if (pc !== 16'h1234) $display("FAIL reset_pc: got %h want 1234", pc); else n_pass++;
    n_checks++;
    if (state !== 3'd0) $display("FAIL reset_state: got %0d want 0", state); else n_pass++;
    n_checks++;
    if (halted !== 1'b0) $display("FAIL reset_halted: got %b want 0", halted); else n_pass++;
  endtask

  task automatic test_nop_stream();
    clear_mems();
    set_iw(0, 16'h003F);
    do_reset(16'h0000);
    step(4);
    n_checks++;
    if (pc !== 16'd1) $display("FAIL nop_pc4: got %0d want 1", pc); else n_pass++;
    step(44);
    n_checks++;
    if (pc !== 16'd12) $display("FAIL nop_pc48: got %0d want 12", pc); else n_pass++;
    for (int r = 0; r < 8; r++) begin
      n_checks++;
      if (dut.rf_q[r] !== 16'h0) $display("FAIL nop_reg%0d: got %h want 0000", r, dut.rf_q[r]);
      else n_pass++;
    end
  endtask

  task automatic test_li_wrap();
    clear_mems();
    set_iw(4095, 16'h7FE0);  // LI r7,-32
    set_iw(0, 16'h7205);     // LI r1,5
    do_reset(16'd4095);
    step(4);
    n_checks++;
    if (dut.rf_q[7] !== 16'hFFE0) $display("FAIL wrap_r7: got %h want ffe0", dut.rf_q[7]);
    else n_pass++;
    n_checks++;
    if (pc !== 16'h1000) $display("FAIL wrap_pc: got %h want 1000", pc); else n_pass++;
    step(4);
    n_checks++;
    if (dut.rf_q[1] !== 16'd5) $display("FAIL wrap_fetch0: got %h want 0005", dut.rf_q[1]);
    else n_pass++;
    n_checks++;
    if (pc !== 16'h1001) $display("FAIL wrap_pc2: got %h want 1001", pc); else n_pass++;
  endtask

  task automatic test_alu();
    logic [15:0] prog [11];
    int          budget;
    prog = '{16'h72F0, 16'h7404, 16'h0650, 16'h0889, 16'h0B0D, 16'h0C56,
             16'h0F17, 16'h0464, 16'h03BB, 16'h0050, 16'hF000};
    clear_mems();
    for (int i = 0; i < 11; i++) set_iw(i, prog[i]);
    do_reset(16'h0000);
    budget = 0;
    while (!halted && budget < 200) begin
      step(1);
      budget++;
    end
    n_checks++;
    if (halted !== 1'b1) $display("FAIL alu_halt_timeout: halted %b want 1", halted);
    else n_pass++;
    n_checks++;
    if (dut.rf_q[3] !== 16'h00F4) $display("FAIL alu_add: got %h want 00f4", dut.rf_q[3]);
    else n_pass++;
    n_checks++;
    if (dut.rf_q[4] !== 16'hFF14) $display("FAIL alu_sub: got %h want ff14", dut.rf_q[4]);
    else n_pass++;
    n_checks++;
    if (dut.rf_q[5] !== 16'h0001) $display("FAIL alu_slt: got %h want 0001", dut.rf_q[5]);
    else n_pass++;
    n_checks++;
    if (dut.rf_q[6] !== 16'h0F00) $display("FAIL alu_sll: got %h want 0f00", dut.rf_q[6]);
    else n_pass++;
    n_checks++;
    if (dut.rf_q[7] !== 16'h0FF1) $display("FAIL alu_srl: got %h want 0ff1", dut.rf_q[7]);
    else n_pass++;
    n_checks++;
    if (dut.rf_q[2] !== 16'hFFE4) $display("FAIL alu_xor: got %h want ffe4", dut.rf_q[2]);
    else n_pass++;
    n_checks++;
    if (dut.rf_q[1] !== 16'h0FF1) $display("FAIL alu_or: got %h want 0ff1", dut.rf_q[1]);
    else n_pass++;
    n_checks++;
    if (dut.rf_q[0] !== 16'h0000) $display("FAIL alu_r0: got %h want 0000", dut.rf_q[0]);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    clear_mems();
    set_iw(0, 16'h7205);  // LI r1,5
    set_iw(1, 16'h7403);  // LI r2,3
    set_iw(2, 16'h3282);  // SW r1,2(r2)
    set_iw(3, 16'h2682);  // LW r3,2(r2)
    set_iw(4, 16'hF000);
    do_reset(16'h0000);
    step(12);
    n_checks++;
    if (dut.dm_q[5] !== 16'd5) $display("FAIL sw_dm5: got %h want 0005", dut.dm_q[5]);
    else n_pass++;
    n_checks++;
    if (pc !== 16'd3) $display("FAIL sw_pc: got %0d want 3", pc); else n_pass++;
    step(4);
    n_checks++;
    if (state !== 3'd4) $display("FAIL lw_state_wb: got %0d want 4", state); else n_pass++;
    n_checks++;
    if (dut.rf_q[3] !== 16'd0) $display("FAIL lw_early: got %h want 0000", dut.rf_q[3]);
    else n_pass++;
    step(1);
    n_checks++;
    if (dut.rf_q[3] !== 16'd5) $display("FAIL lw_r3: got %h want 0005", dut.rf_q[3]);
    else n_pass++;
    n_checks++;
    if (state !== 3'd0 || pc !== 16'd4)
      $display("FAIL lw_done: got state %0d pc %0d want state 0 pc 4", state, pc);
    else n_pass++;
  endtask

  task automatic test_branch();
    clear_mems();
    set_iw(10, 16'h4242);  // BEQ r1,r1,+2
    do_reset(16'd10);
    step(3);
    n_checks++;
    if (pc !== 16'd13) $display("FAIL beq_taken: got %0d want 13", pc); else n_pass++;
    set_iw(10, 16'h5242);  // BNE r1,r1,+2
    do_reset(16'd10);
    step(3);
    n_checks++;
    if (pc !== 16'd11) $display("FAIL bne_not_taken: got %0d want 11", pc); else n_pass++;
    set_iw(20, 16'h7205);  // LI r1,5
    set_iw(21, 16'h523D);  // BNE r1,r0,-3
    do_reset(16'd20);
    step(7);
    n_checks++;
    if (pc !== 16'd19) $display("FAIL bne_back: got %0d want 19", pc); else n_pass++;
    set_iw(5, 16'h6ABC);   // JMP 0xABC
    do_reset(16'h3005);
    step(3);
    n_checks++;
    if (pc !== 16'h3ABC) $display("FAIL jmp: got %h want 3abc", pc); else n_pass++;
  endtask

  task automatic test_halt();
    clear_mems();
    set_iw(2, 16'hF000);
    do_reset(16'h0000);
    step(9);
    n_checks++;
    if (state !== 3'd1 || halted !== 1'b0)
      $display("FAIL halt_decode: got state %0d halted %b want 1 0", state, halted);
    else n_pass++;
    step(1);
    n_checks++;
    if (state !== 3'd5 || halted !== 1'b1)
      $display("FAIL halt_enter: got state %0d halted %b want 5 1", state, halted);
    else n_pass++;
    step(20);
    n_checks++;
    if (state !== 3'd5 || halted !== 1'b1 || pc !== 16'd3)
      $display("FAIL halt_hold: got state %0d halted %b pc %0d want 5 1 3", state, halted, pc);
    else n_pass++;
    do_reset(16'h0040);
    n_checks++;
    if (state !== 3'd0 || halted !== 1'b0 || pc !== 16'h0040)
      $display("FAIL halt_reset: got state %0d halted %b pc %h want 0 0 0040", state, halted, pc);
    else n_pass++;
  endtask

  task automatic test_reset_in_mem();
    clear_mems();
    set_dw(5, 16'hAAAA);
    set_iw(0, 16'h7205);
    set_iw(1, 16'h7403);
    set_iw(2, 16'h3282);
    do_reset(16'h0000);
    step(11);
    n_checks++;
    if (state !== 3'd3) $display("FAIL sw_in_mem: got %0d want 3", state); else n_pass++;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    n_checks++;
    if (dut.dm_q[5] !== 16'hAAAA) $display("FAIL abort_dm: got %h want aaaa", dut.dm_q[5]);
    else n_pass++;
    n_checks++;
    if (state !== 3'd0 || pc !== 16'h0000)
      $display("FAIL abort_state: got state %0d pc %h want 0 0000", state, pc);
    else n_pass++;
    n_checks++;
    if (dut.rf_q[1] !== 16'h0) $display("FAIL abort_rf: got %h want 0000", dut.rf_q[1]);
    else n_pass++;
  endtask

  task automatic test_imem_change();
    clear_mems();
    set_iw(0, 16'h7205);
    do_reset(16'h0000);
    step(1);
    set_iw(0, 16'h7207);
    step(3);
    n_checks++;
    if (dut.rf_q[1] !== 16'd5) $display("FAIL imem_stable: got %h want 0005", dut.rf_q[1]);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    pc_nu    = '0;
    instrmem = '0;
    datamem  = '0;
    test_reset();
    test_nop_stream();
    test_li_wrap();
    test_alu();
    test_back_to_back();
    test_branch();
    test_halt();
    test_reset_in_mem();
    test_imem_change();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
